color_sensor_driver: RTL and testbench

- Free-running driver for a TCS3200-style light-to-frequency colour sensor.
- Steps the sensor's photodiode filter through red, green and blue. For each filter it counts sensor output pulses over a fixed gate window and publishes the three counts together with a one-cycle valid strobe.
- Sits between the sensor pins and the colour-classification logic. It is the top-level `driver` wrapper's only functional block.

---
 rtl/color_pkg.sv | 24 ++
 rtl/color_sensor_driver_pulse_counter.sv | 53 +++++
 rtl/color_sensor_driver.sv | 151 +++++++++++++++
 tb/tb_color_sensor_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and codes for the TCS3200-style colour sensor driver.
// Holds the sequencer state enum and the sensor pin encodings.
package color_pkg;

    typedef enum logic [2:0] {
        SEL_R,
        MEAS_R,
        SEL_G,
        MEAS_G,
        SEL_B,
        MEAS_B,
        PUBLISH
    } state_t;

    // Photodiode filter select, ordered as {s2, s3}
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    // Output frequency scaling, ordered as {s0, s1}
    localparam logic [1:0] SCALE_20 = 2'b10;

endpackage

// File: rtl/color_sensor_driver_pulse_counter.sv
// Synchronises the sensor square wave, detects rising edges and
// counts them into a saturating counter with clear and enable.
module pulse_counter
    import color_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_out,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // sync[1] is the synchronised level, sync[2] its one-cycle delay
    logic [2:0]       sync;
    logic             pulse_edge;
    logic [CNT_W-1:0] count;

    // Two-stage synchroniser followed by a delay stage for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], sensor_out};
        end
    end

    assign pulse_edge = sync[1] & ~sync[2];

    // Next count: cleared, or bumped on an edge while enabled and not full
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && pulse_edge && (count != CNT_MAX)) begin
            count_next = count + 1'b1;
        end
    end

    // Working count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/color_sensor_driver.sv
// Free-running R/G/B measurement sequencer for a light-to-frequency
// colour sensor; publishes three gated pulse counts with a strobe.
module color_sensor_driver
    import color_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int GATE_CYCLES   = 500_000,
    parameter int SETTLE_CYCLES = 5_000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_out,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             oe_n,
    output logic [CNT_W-1:0] r_cnt,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] b_cnt,
    output logic             valid
);

    localparam int MAX_LEN = (GATE_CYCLES > SETTLE_CYCLES) ?
                             GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_LEN + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 1 || SETTLE_CYCLES < 1 || CLK_HZ < 1) begin : g_param_check
        $error("color_sensor_driver: parameters must be positive");
    end

    // rst_n is active-high despite its name
    logic             rst;
    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;
    logic             settle_done;
    logic             gate_done;
    logic [1:0]       filt;
    logic             clear;
    logic             enable;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] g_shadow;
    logic [CNT_W-1:0] b_shadow;

    assign rst = rst_n;

    assign settle_done = (timer == SETTLE_LAST);
    assign gate_done   = (timer == GATE_LAST);

    assign {s0, s1} = SCALE_20;
    assign {s2, s3} = filt;

    pulse_counter #(
        .CNT_W(CNT_W)
    ) u_pulse_counter (
        .clk       (clk),
        .rst       (rst),
        .sensor_out(sensor_out),
        .clear     (clear),
        .enable    (enable),
        .count_next(count_next)
    );

    // State register and per-state timer, restarted on every transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEL_R;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= (state_next != state) ? '0 : timer + 1'b1;
        end
    end

    // Sequencer: filter select, counter control and next state
    always_comb begin
        state_next = state;
        filt       = FILT_RED;
        clear      = 1'b0;
        enable     = 1'b0;
        unique case (state)
            SEL_R: begin
                clear = 1'b1;
                if (settle_done) state_next = MEAS_R;
            end
            MEAS_R: begin
                enable = 1'b1;
                if (gate_done) state_next = SEL_G;
            end
            SEL_G: begin
                filt  = FILT_GREEN;
                clear = 1'b1;
                if (settle_done) state_next = MEAS_G;
            end
            MEAS_G: begin
                filt   = FILT_GREEN;
                enable = 1'b1;
                if (gate_done) state_next = SEL_B;
            end
            SEL_B: begin
                filt  = FILT_BLUE;
                clear = 1'b1;
                if (settle_done) state_next = MEAS_B;
            end
            MEAS_B: begin
                filt   = FILT_BLUE;
                enable = 1'b1;
                if (gate_done) state_next = PUBLISH;
            end
            PUBLISH: begin
                clear      = 1'b1;
                state_next = SEL_R;
            end
            default: begin
                state_next = SEL_R;
            end
        endcase
    end

    // Capture each gate's final count, then publish all three together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            g_shadow <= '0;
            b_shadow <= '0;
            r_cnt    <= '0;
            g_cnt    <= '0;
            b_cnt    <= '0;
            valid    <= 1'b0;
            oe_n     <= 1'b1;
        end else begin
            oe_n  <= 1'b0;
            valid <= (state == PUBLISH);
            if (state == MEAS_R && gate_done) r_shadow <= count_next;
            if (state == MEAS_G && gate_done) g_shadow <= count_next;
            if (state == MEAS_B && gate_done) b_shadow <= count_next;
            if (state == PUBLISH) begin
                r_cnt <= r_shadow;
                g_cnt <= g_shadow;
                b_cnt <= b_shadow;
            end
        end
    end

endmodule

// File: tb/tb_color_sensor_driver.sv
// Self-checking bench for color_sensor_driver: scenario table, an
// edge-counting reference model over the recorded pin history, and a reset sequence.
module tb_color_sensor_driver;

    localparam int GATE   = 100;
    localparam int SETTLE = 10;
    localparam int SLOT   = GATE + SETTLE;
    localparam int PERIOD = 3 * SLOT + 1;
    localparam int W      = 8;
    localparam int SW     = 4;
    localparam int HMAX   = 4096;

    localparam int M_FILT  = 0;
    localparam int M_RAND  = 1;
    localparam int M_BLANK = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          pin = 1'b0;
    logic          s0, s1, s2, s3, oe_n, valid;
    logic [W-1:0]  r_cnt, g_cnt, b_cnt;

    logic          sat_pin = 1'b0;
    logic          sat_s0, sat_s1, sat_s2, sat_s3, sat_oe_n, sat_valid;
    logic [SW-1:0] sat_r, sat_g, sat_b;

    color_sensor_driver #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor_out(pin),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .oe_n(oe_n),
        .r_cnt(r_cnt), .g_cnt(g_cnt), .b_cnt(b_cnt), .valid(valid)
    );

    color_sensor_driver #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(SW)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .sensor_out(sat_pin),
        .s0(sat_s0), .s1(sat_s1), .s2(sat_s2), .s3(sat_s3),
        .oe_n(sat_oe_n), .r_cnt(sat_r), .g_cnt(sat_g), .b_cnt(sat_b),
        .valid(sat_valid)
    );

    typedef struct {
        int mode;
        int periods;
        int er;
        int eg;
        int eb;
        int tol;
    } vec_t;

    vec_t tbl[3];

    bit   hist[HMAX];
    int   cyc;
    int   nchk = 0;
    int   nfail = 0;
    int   nvalid;
    int   mode;
    int   ph;
    logic [1:0] last_filt;
    int   cur_er, cur_eg, cur_eb, cur_tol;
    int   last_r, last_g, last_b;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic check_tol(input string name, input int act,
                             input int exp, input int tol);
        nchk++;
        if (act < exp - tol || act > exp + tol) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Rising pin transitions inside the counted window of period n,
    // colour c, shifted by the three-cycle input lag; saturated to W bits.
    function automatic int model(input int n, input int c);
        int start;
        int cnt;
        start = n * PERIOD + c * SLOT + SETTLE - 1;
        cnt = 0;
        for (int j = start; j < start + GATE; j++) begin
            if (j >= 1 && j < HMAX && hist[j] && !hist[j-1]) cnt++;
        end
        return (cnt > (2**W - 1)) ? (2**W - 1) : cnt;
    endfunction

    function automatic bit in_sel(input int pos);
        return (pos >= 1 && pos <= 7) ||
               (pos >= SLOT + 1 && pos <= SLOT + 7) ||
               (pos >= 2*SLOT + 1 && pos <= 2*SLOT + 7);
    endfunction

    task automatic next_pin();
        logic v;
        int   per;
        int   pos;
        v = 1'b0;
        case (mode)
            M_FILT: begin
                if ({s2, s3} != last_filt) begin
                    ph = 0;
                    last_filt = {s2, s3};
                end
                per = ({s2, s3} == 2'b00) ? 4 :
                      ({s2, s3} == 2'b11) ? 5 : 10;
                v = (ph < per / 2);
                ph = (ph + 1) % per;
            end
            M_RAND: begin
                v = ($urandom_range(0, 2) == 0) ? ~pin : pin;
            end
            default: begin
                pos = (cyc + 1) % PERIOD;
                v = in_sel(pos) && (pos % 2 == 1);
            end
        endcase
        pin = v;
        if (cyc + 1 < HMAX) hist[cyc + 1] = v;
        sat_pin = ~sat_pin;
    endtask

    task automatic observe();
        int n;
        if (valid) begin
            nvalid++;
            check("valid_phase", cyc % PERIOD, 0);
            n = cyc / PERIOD - 1;
            check("r_model", int'(r_cnt), model(n, 0));
            check("g_model", int'(g_cnt), model(n, 1));
            check("b_model", int'(b_cnt), model(n, 2));
            if (cur_tol >= 0) begin
                check_tol("r_expect", int'(r_cnt), cur_er, cur_tol);
                check_tol("g_expect", int'(g_cnt), cur_eg, cur_tol);
                check_tol("b_expect", int'(b_cnt), cur_eb, cur_tol);
            end
            last_r = int'(r_cnt);
            last_g = int'(g_cnt);
            last_b = int'(b_cnt);
        end else begin
            check("cnt_stable",
                  (int'(r_cnt) == last_r && int'(g_cnt) == last_g &&
                   int'(b_cnt) == last_b) ? 1 : 0, 1);
        end
        if (sat_valid) begin
            check("sat_r", int'(sat_r), 15);
            check("sat_g", int'(sat_g), 15);
            check("sat_b", int'(sat_b), 15);
        end
    endtask

    task automatic assert_rst(input int hold);
        @(negedge clk);
        rst_n = 1'b1;
        pin = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    task automatic release_rst();
        rst_n = 1'b0;
        cyc = 0;
        for (int i = 0; i < HMAX; i++) hist[i] = 1'b0;
        ph = 0;
        last_filt = 2'b00;
        last_r = 0;
        last_g = 0;
        last_b = 0;
        nvalid = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            next_pin();
            @(posedge clk);
            cyc++;
            @(negedge clk);
            observe();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe_n"}, int'(oe_n), 1);
        check({tag, "_s0s1"}, int'({s0, s1}), 2);
        check({tag, "_s2s3"}, int'({s2, s3}), 0);
        check({tag, "_valid"}, int'(valid | sat_valid), 0);
        check({tag, "_cnts"}, int'(r_cnt) + int'(g_cnt) + int'(b_cnt), 0);
    endtask

    initial begin
        tbl[0] = '{mode: M_FILT,  periods: 3, er: 25, eg: 20, eb: 10, tol: 1};
        tbl[1] = '{mode: M_BLANK, periods: 1, er: 0,  eg: 0,  eb: 0,  tol: 0};
        tbl[2] = '{mode: M_RAND,  periods: 2, er: 0,  eg: 0,  eb: 0,  tol: -1};
        mode = M_FILT;
        cur_tol = -1;
        cyc = 0;

        for (int t = 0; t < 3; t++) begin
            assert_rst(3);
            check_reset_outputs("reset");
            mode    = tbl[t].mode;
            cur_er  = tbl[t].er;
            cur_eg  = tbl[t].eg;
            cur_eb  = tbl[t].eb;
            cur_tol = tbl[t].tol;
            release_rst();
            run(1);
            check("rel_oe_n", int'(oe_n), 0);
            check("rel_s0s1", int'({s0, s1}), 2);
            check("rel_s2s3", int'({s2, s3}), 0);
            run(tbl[t].periods * PERIOD + 1);
            check("valid_count", nvalid, tbl[t].periods);
        end

        // Reset during the green gate of the second period
        mode = M_RAND;
        cur_tol = -1;
        assert_rst(3);
        release_rst();
        run(PERIOD + 150);
        check("pre_abort_valids", nvalid, 1);
        rst_n = 1'b1;
        pin = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("abort");
        end
        release_rst();
        run(PERIOD - 1);
        check("post_abort_early", nvalid, 0);
        run(3);
        check("post_abort_valids", nvalid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
